icm_lookup_rr_arbiter: RTL
==========================

# icm_lookup_rr_arbiter

N-channel, parametrised arbiter in the ICM cache metadata path. It shares one ICM lookup engine among `CHNL_NUM` requesters using round-robin grant with real ready/valid back-pressure. It registers the selected lookup toward the engine and tracks outstanding lookups in an in-order channel-tag FIFO. Each in-order engine response is returned only to the channel that issued it, not broadcast.

## Interface
- `CHNL_NUM`, 4: number of requesting channels, 2..16.
- `CHNL_ID_W`, `log2b(CHNL_NUM-1)`: channel tag width.
- `ICM_ENTRY_NUM`, `` `ICM_ENTRY_NUM_MPT``: ICM entry count.
- `ICM_ENTRY_NUM_LOG`, `log2b(ICM_ENTRY_NUM-1)`: head index width (H).
- `MAX_OUTSTANDING`, 8: tag FIFO depth, power of two, ≥2.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `chnl_lookup_valid` in CHNL_NUM: per-channel request valid.
- `chnl_lookup_head` in CHNL_NUM*H: channel i at bits [i*H +: H].
- `chnl_lookup_ready` out CHNL_NUM: one-hot grant.
- `chnl_rsp_valid` out CHNL_NUM: routed response valid.
- `chnl_rsp_icm_addr` out CHNL_NUM*`` `ICM_SPACE_ADDR_WIDTH``: response ICM address, replicated to every channel.
- `chnl_rsp_phy_addr` out CHNL_NUM*`` `PHY_SPACE_ADDR_WIDTH``: response physical address, replicated to every channel.
- `chnl_rsp_ready` in CHNL_NUM: per-channel response ready.
- `lookup_valid` out 1: registered request to the engine.
- `lookup_head` out H: registered request head.
- `lookup_ready` in 1: engine accepts the request.
- `rsp_valid` in 1: engine response valid; responses arrive in request order.
- `rsp_icm_addr` in `` `ICM_SPACE_ADDR_WIDTH``: engine response ICM address.
- `rsp_phy_addr` in `` `PHY_SPACE_ADDR_WIDTH``: engine response physical address.
- `rsp_ready` out 1: back-pressure to the engine.
- `orphan_rsp_err` out 1: sticky flag, response received with no outstanding tag.

## Operation
- **Grant enable:** `can_issue = (!lookup_valid | lookup_ready) & (out_cnt < MAX_OUTSTANDING)`.
  - `out_cnt` is the number of tags in the FIFO.
  - A pop in the same cycle does not relax the full check.
- **Arbitration:**
  - Search order is `rr_ptr`, `rr_ptr+1`, … mod CHNL_NUM; the first valid channel wins.
  - `chnl_lookup_ready[w] = can_issue & chnl_lookup_valid[w]`; all other bits are 0.
  - On grant, `rr_ptr <= (w+1) mod CHNL_NUM`.
  - With no grant, `rr_ptr` holds.
- **Issue register:**
  - On grant: `lookup_valid <= 1`, `lookup_head <= head[w]`, and `w` is pushed into the tag FIFO.
  - Else if `lookup_ready`: `lookup_valid <= 0`.
  - `lookup_head` holds while `lookup_valid & !lookup_ready`.
- **Response routing:** `t` = FIFO head tag, `ne` = FIFO not empty.
  - `chnl_rsp_valid[i] = rsp_valid & ne & (t==i)`.
  - `rsp_ready = ne ? chnl_rsp_ready[t] : 1`.
  - Address buses are driven for all channels, ungated.
  - Pop the FIFO on `rsp_valid & rsp_ready & ne`.
- **Orphan response:** `rsp_valid & !ne` is accepted and dropped, and sets `orphan_rsp_err`. Only reset clears the flag.
- **Counter:** `out_cnt` is (CHNL_ID_W..) width `log2(MAX_OUTSTANDING)+1`. It gets +1 on push, -1 on pop, and is unchanged on a simultaneous push and pop. Read and write pointers wrap modulo MAX_OUTSTANDING.

## Timing
- **Reset (async assert, sync release):** `lookup_valid=0`, `lookup_head=0`, `rr_ptr=0`, `out_cnt=0`, FIFO pointers 0, `orphan_rsp_err=0`.
  - Combinational outputs then evaluate to `chnl_lookup_ready=0` (absent requests), `chnl_rsp_valid=0`, and `rsp_ready=1`.
- **Request latency:** a grant in cycle T gives `lookup_valid=1` in T+1.
  - Back-to-back grants are possible every cycle while `lookup_ready=1`.
- **Response path:** combinational, zero latency from `rsp_valid` to `chnl_rsp_valid` and from `chnl_rsp_ready` to `rsp_ready`.
- **Tag timing:** a tag pushed in cycle T is poppable from T+1. A response in the grant cycle itself is treated as an orphan.
- **Reset mid-operation:** all outstanding tags are discarded, and responses returned after reset flag an orphan.
- Channels must hold valid and head until their ready is seen. Engine responses must hold until `rsp_ready` is seen.

## Test plan
- **Round-robin rotation:** CHNL_NUM=4, all valid, `lookup_ready=1` → grants 0,1,2,3,0 in consecutive cycles; `lookup_head` follows one cycle later.
- **Engine stall:** `lookup_ready=0` for 3 cycles with head 0x15 registered → head holds 0x15, no new grant, and `rr_ptr` is unchanged until ready.
- **Outstanding limit:** MAX_OUTSTANDING=8, no responses → exactly 8 grants, then `chnl_lookup_ready=0`. One response is then popped; the next grant follows on the following cycle.
- **In-order routing:** grants ch2, ch0, ch2 → the three responses assert `chnl_rsp_valid` = 0100, 0001, 0100 with matching addresses.
- **Response back-pressure:** head tag ch1 with `chnl_rsp_ready[1]=0` → `rsp_ready=0`, the FIFO is not popped, and ch3 readiness is ignored.
- **Orphan and reset:** `rsp_valid` with an empty FIFO → `rsp_ready=1`, `orphan_rsp_err` sets and persists. Asserting `rst_n=0` mid-burst clears all state asynchronously.

Source files
------------

// File: rtl/icm_lookup_rr_arbiter.sv
// Round-robin arbiter sharing one ICM lookup engine among CHNL_NUM channels,
// with a registered issue stage and an in-order channel-tag FIFO for response routing.
`ifndef ICM_ENTRY_NUM_MPT
`define ICM_ENTRY_NUM_MPT 256
`endif
`ifndef ICM_SPACE_ADDR_WIDTH
`define ICM_SPACE_ADDR_WIDTH 32
`endif
`ifndef PHY_SPACE_ADDR_WIDTH
`define PHY_SPACE_ADDR_WIDTH 40
`endif

module icm_lookup_rr_arbiter #(
    parameter int CHNL_NUM          = 4,
    parameter int CHNL_ID_W         = $clog2(CHNL_NUM),
    parameter int ICM_ENTRY_NUM     = `ICM_ENTRY_NUM_MPT,
    parameter int ICM_ENTRY_NUM_LOG = $clog2(ICM_ENTRY_NUM),
    parameter int MAX_OUTSTANDING   = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [CHNL_NUM-1:0]                           chnl_lookup_valid,
    input  logic [CHNL_NUM*ICM_ENTRY_NUM_LOG-1:0]         chnl_lookup_head,
    output logic [CHNL_NUM-1:0]                           chnl_lookup_ready,
    output logic [CHNL_NUM-1:0]                           chnl_rsp_valid,
    output logic [CHNL_NUM*`ICM_SPACE_ADDR_WIDTH-1:0]     chnl_rsp_icm_addr,
    output logic [CHNL_NUM*`PHY_SPACE_ADDR_WIDTH-1:0]     chnl_rsp_phy_addr,
    input  logic [CHNL_NUM-1:0]                           chnl_rsp_ready,
    output logic                                          lookup_valid,
    output logic [ICM_ENTRY_NUM_LOG-1:0]                  lookup_head,
    input  logic                                          lookup_ready,
    input  logic                                          rsp_valid,
    input  logic [`ICM_SPACE_ADDR_WIDTH-1:0]              rsp_icm_addr,
    input  logic [`PHY_SPACE_ADDR_WIDTH-1:0]              rsp_phy_addr,
    output logic                                          rsp_ready,
    output logic                                          orphan_rsp_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int H     = ICM_ENTRY_NUM_LOG;

    // Handshake rule on every interface: a transfer happens in a cycle where
    // valid and ready are both high; the source holds its payload until then.

    logic [CHNL_ID_W-1:0] rr_ptr;
    logic [CHNL_ID_W-1:0] grant_idx;
    logic [CHNL_ID_W:0]   cand;
    logic                 grant_any;
    logic                 can_issue;
    logic                 grant;

    logic [CHNL_ID_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     out_cnt;
    logic [CHNL_ID_W-1:0] head_tag;
    logic                 fifo_ne;
    logic                 pop;

    assign can_issue = (!lookup_valid || lookup_ready) && (out_cnt < CNT_W'(MAX_OUTSTANDING));
    assign grant     = grant_any && can_issue;

    // First valid channel in the order rr_ptr, rr_ptr+1, ... wrapping at CHNL_NUM.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < CHNL_NUM; k++) begin
            cand = {1'b0, rr_ptr} + (CHNL_ID_W+1)'(k);
            if (cand >= (CHNL_ID_W+1)'(CHNL_NUM))
                cand = cand - (CHNL_ID_W+1)'(CHNL_NUM);
            if (!grant_any && chnl_lookup_valid[cand[CHNL_ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[CHNL_ID_W-1:0];
            end
        end
    end

    always_comb begin
        chnl_lookup_ready = '0;
        if (grant)
            chnl_lookup_ready[grant_idx] = 1'b1;
    end

    assign fifo_ne  = (out_cnt != '0);
    assign head_tag = tag_mem[rd_ptr];
    assign rsp_ready = fifo_ne ? chnl_rsp_ready[head_tag] : 1'b1;
    assign pop      = rsp_valid && rsp_ready && fifo_ne;

    always_comb begin
        chnl_rsp_valid = '0;
        if (rsp_valid && fifo_ne)
            chnl_rsp_valid[head_tag] = 1'b1;
    end

    assign chnl_rsp_icm_addr = {CHNL_NUM{rsp_icm_addr}};
    assign chnl_rsp_phy_addr = {CHNL_NUM{rsp_phy_addr}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            lookup_valid   <= 1'b0;
            lookup_head    <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            out_cnt        <= '0;
            orphan_rsp_err <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr       <= (grant_idx == CHNL_ID_W'(CHNL_NUM-1)) ? '0 : grant_idx + 1'b1;
                lookup_valid <= 1'b1;
                lookup_head  <= chnl_lookup_head[grant_idx*H +: H];
                wr_ptr       <= wr_ptr + 1'b1;
            end else if (lookup_ready) begin
                lookup_valid <= 1'b0;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({grant, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            // A response with nothing outstanding is consumed and dropped.
            if (rsp_valid && !fifo_ne)
                orphan_rsp_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[wr_ptr] <= grant_idx;
    end

endmodule
